// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: loader state encodings (3 bits), the instruction word width and
// the width of the frame word-count field.
package imem_loader_pkg;

    // Instruction word width used across the CPU codebase.
    localparam int LD_WORD_W = 32;
    // Frame header carries a 16-bit little-endian word count.
    localparam int LD_CNT_W  = 16;

    typedef enum logic [2:0] {
        LD_HDR_LO = 3'd0,
        LD_HDR_HI = 3'd1,
        LD_DATA   = 3'd2,
        LD_CSUM   = 3'd3,
        LD_DONE   = 3'd4,
        LD_ERROR  = 3'd5
    } ld_state_t;

    // States in which the loader is consuming stream bytes.
    function automatic logic ld_takes_bytes(input ld_state_t s);
        return (s == LD_HDR_LO) || (s == LD_HDR_HI) ||
               (s == LD_DATA)   || (s == LD_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts stream bytes into little-endian 32-bit words, one byte lane at a time.
// Latency: word_vld/word_dat registered one cycle after the lane-3 byte.
// Backpressure: none; consumes every byte_vld, caller gates acceptance.
//
// Ports: clk, reset (sync, active-high), clear (drop partial word),
//        byte_vld/byte_dat (accepted byte), lane (next byte lane 0..3),
//        word_vld (one-cycle pulse), word_dat (assembled word, held).
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 byte_vld,
    input  logic [7:0]           byte_dat,
    output logic [1:0]           lane,
    output logic                 word_vld,
    output logic [LD_WORD_W-1:0] word_dat
);

    logic [1:0]  lane_q;
    logic [23:0] acc_q;    // bytes 0..2 of the word in progress, byte 0 lowest

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q   <= 2'd0;
            acc_q    <= 24'd0;
            word_vld <= 1'b0;
            word_dat <= '0;
        end else begin
            // A word registered on the previous edge still presents for its
            // one cycle even if clear arrives now.
            word_vld <= 1'b0;
            if (clear) begin
                lane_q <= 2'd0;
                acc_q  <= 24'd0;
            end else if (byte_vld) begin
                if (lane_q == 2'd3) begin
                    word_dat <= {byte_dat, acc_q};
                    word_vld <= 1'b1;
                    lane_q   <= 2'd0;
                    acc_q    <= 24'd0;
                end else begin
                    // Shift down so that after three bytes acc = {b2, b1, b0}.
                    acc_q  <= {byte_dat, acc_q[23:8]};
                    lane_q <= lane_q + 2'd1;
                end
            end
        end
    end

    assign lane = lane_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> sequential instruction-memory writes, holds CPU in reset until loaded.
// Latency: mem_we one cycle after the 4th byte of a word; done with the final write (or checksum).
// Backpressure: in_ready low only in DONE/ERROR and during restart; otherwise a byte every cycle.
//
// Ports: clk, reset (sync, active-high), restart (pulse, re-arm for a new header),
//        in_data/in_valid/in_ready (byte stream), mem_we/mem_addr/mem_wdata (imem write),
//        cpu_hold (CPU reset), done, error.
// Option: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR-of-payload byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH     = LD_WORD_W,
    parameter int ADDR_BITS = 8,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    ld_state_t             state_q, state_d;
    logic [LD_CNT_W-1:0]   count_q;
    logic [ADDR_BITS-1:0]  word_idx_q;
    logic [ADDR_BITS-1:0]  mem_addr_q;
    logic [1:0]            lane;
    logic                  byte_fire;
    logic                  data_fire;
    logic                  word_fire;
    logic                  last_word;
    logic [LD_CNT_W-1:0]   hdr_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign in_ready  = ld_takes_bytes(state_q) && !restart;
    assign byte_fire = in_valid && in_ready;
    assign data_fire = byte_fire && (state_q == LD_DATA);
    assign word_fire = data_fire && (lane == 2'd3);
    // Full count as it will be once the high byte lands this cycle.
    assign hdr_n     = {in_data, count_q[7:0]};
    assign last_word = (LD_CNT_W'(word_idx_q) == (count_q - LD_CNT_W'(1)));

    word_assembler u_word_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .byte_vld (data_fire),
        .byte_dat (in_data),
        .lane     (lane),
        .word_vld (mem_we),
        .word_dat (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_HDR_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = LD_HDR_LO;
        end else begin
            case (state_q)
                LD_HDR_LO: if (byte_fire) state_d = LD_HDR_HI;
                LD_HDR_HI: begin
                    if (byte_fire) begin
                        if (hdr_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = LD_CSUM;   // empty image still carries a 0x00 checksum
`else
                            state_d = LD_DONE;
`endif
                        end else if (hdr_n > LD_CNT_W'(DEPTH)) begin
                            state_d = LD_ERROR;
                        end else begin
                            state_d = LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (word_fire && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = LD_CSUM;
`else
                        state_d = LD_DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    if (byte_fire) begin
                        state_d = (in_data == csum_q) ? LD_DONE : LD_ERROR;
                    end
                end
`endif
                LD_DONE:  state_d = LD_DONE;
                LD_ERROR: state_d = LD_ERROR;
                default:  state_d = LD_HDR_LO;
            endcase
        end
    end

    // Frame bookkeeping; cleared by restart so a new header starts from scratch.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count_q    <= '0;
            word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            if (byte_fire && (state_q == LD_HDR_LO)) begin
                count_q[7:0] <= in_data;
            end
            if (byte_fire && (state_q == LD_HDR_HI)) begin
                count_q[15:8] <= in_data;
            end
            if (word_fire) begin
                word_idx_q <= word_idx_q + ADDR_BITS'(1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (data_fire) begin
                csum_q <= csum_q ^ in_data;
            end
`endif
        end
    end

    // Address register is not cleared by restart: a write already in flight
    // must still present its own address.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
        end else if (word_fire) begin
            mem_addr_q <= word_idx_q;
        end
    end

    assign mem_addr = mem_addr_q;
    assign cpu_hold = (state_q != LD_DONE);
    assign done     = (state_q == LD_DONE);
    assign error    = (state_q == LD_ERROR);

endmodule
